// File: rtl/tdm_mux_pkg.sv
// Shared types and helpers for the time-division output multiplexer.
// The scan-order helper is only exercised when CH_MASK_EN is defined.
package tdm_mux_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

  // Upper bound on channel count that next_ch can search.
  localparam int unsigned MAX_CH = 64;

  // Returns the lowest index above ptr (ptr = -1 searches from 0) whose
  // mask bit is set and which lies below n; returns n when there is none.
  function automatic int next_ch(input logic [MAX_CH-1:0] mask, input int ptr, input int n);
    int r;
    r = n;
    for (int unsigned i = 0; i < MAX_CH; i++) begin
      if (r == n && int'(i) > ptr && int'(i) < n && mask[i]) begin
        r = int'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/tdm_next_ch.sv
// Combinational finder for the next enabled scan channel above ptr,
// or the first enabled channel when from_zero is set.
module tdm_next_ch
  import tdm_mux_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  en,
  input  logic [SEL_W-1:0] ptr,
  input  logic             from_zero,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  logic [MAX_CH-1:0] en_w;
  int                base;
  int                r;

  always_comb begin
    en_w            = '0;
    en_w[N_CH-1:0]  = en;
    base            = from_zero ? -1 : int'(32'(ptr));
    r               = next_ch(en_w, base, N_CH);
    found           = (r < N_CH);
    nxt             = SEL_W'(r);
  end

endmodule

// File: rtl/tdm_mux_scan.sv
// N-channel registered multiplexer with manual select and ascending scan bursts.
// Optional CH_MASK_EN adds ch_mask to skip channels during a scan.
module tdm_mux_scan
  import tdm_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int W     = 1,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH*W-1:0] d,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel_in,
  input  logic              start,
  input  logic              out_ready,
  output logic [W-1:0]      y,
  output logic [SEL_W-1:0]  y_ch,
  output logic              y_valid,
  output logic              sel_err,
  output logic              busy,
  output logic              done
`ifdef CH_MASK_EN
  ,
  input  logic [N_CH-1:0]   ch_mask
`endif
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic             load;
  logic             sel_ok;
  logic [W-1:0]     man_data;
  logic [W-1:0]     scan_data;
  logic [SEL_W-1:0] first_ch;
  logic             any_en;
  logic [SEL_W-1:0] nxt_ch;
  logic             is_last;

  assign load   = !y_valid || out_ready;
  assign sel_ok = ({1'b0, sel_in} < (SEL_W+1)'(N_CH));

  // Out-of-range indices match no channel, so both selections fall back to zero.
  always_comb begin
    man_data  = '0;
    scan_data = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (32'(sel_in) == k) man_data = d[k*W +: W];
      if (32'(ptr) == k)    scan_data = d[k*W +: W];
    end
  end

`ifdef CH_MASK_EN
  logic [N_CH-1:0] en_q;
  logic            has_next;

  tdm_next_ch #(
    .N_CH (N_CH),
    .SEL_W(SEL_W)
  ) u_first (
    .en       (~ch_mask),
    .ptr      ('0),
    .from_zero(1'b1),
    .nxt      (first_ch),
    .found    (any_en)
  );

  tdm_next_ch #(
    .N_CH (N_CH),
    .SEL_W(SEL_W)
  ) u_next (
    .en       (en_q),
    .ptr      (ptr),
    .from_zero(1'b0),
    .nxt      (nxt_ch),
    .found    (has_next)
  );

  assign is_last = !has_next;
`else
  assign first_ch = '0;
  assign any_en   = 1'b1;
  assign nxt_ch   = ptr + SEL_W'(1);
  assign is_last  = (ptr == SEL_W'(N_CH - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      y       <= '0;
      y_ch    <= '0;
      y_valid <= 1'b0;
      sel_err <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef CH_MASK_EN
      en_q    <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (load) begin
        unique case (state)
          IDLE: begin
            if (!mode) begin
              y       <= sel_ok ? man_data : '0;
              y_ch    <= sel_in;
              y_valid <= 1'b1;
              sel_err <= !sel_ok;
            end else begin
              y_valid <= 1'b0;
              if (start) begin
`ifdef CH_MASK_EN
                en_q <= ~ch_mask;
`endif
                // An empty scan set finishes immediately without leaving IDLE.
                if (any_en) begin
                  ptr   <= first_ch;
                  state <= SCAN;
                  busy  <= 1'b1;
                end else begin
                  done <= 1'b1;
                end
              end
            end
          end
          SCAN: begin
            y       <= scan_data;
            y_ch    <= ptr;
            y_valid <= 1'b1;
            ptr     <= nxt_ch;
            if (is_last) state <= DRAIN;
          end
          DRAIN: begin
            // y_valid is always set here, so load implies the last beat is accepted.
            done    <= 1'b1;
            y_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_mux_scan.sv
// Self-checking bench: two instances (4 and 5 channels, 8-bit) against a set-based model.
module tb_tdm_mux_scan;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  rst;
  logic [1:0]  mode;
  logic [1:0]  start;
  logic [1:0]  rdy;
  logic [31:0] d4;
  logic [39:0] d5;
  logic [1:0]  sel4;
  logic [2:0]  sel5;
`ifdef CH_MASK_EN
  logic [3:0]  mask4;
  logic [4:0]  mask5;
`endif

  logic [7:0]  y4, y5;
  logic [1:0]  ych4;
  logic [2:0]  ych5;
  logic        yv4, yv5, se4, se5, busy4, busy5, done4, done5;

  tdm_mux_scan #(.N_CH(4), .W(8)) u4 (
    .clk(clk), .reset(rst[0]), .d(d4), .mode(mode[0]), .sel_in(sel4),
    .start(start[0]), .out_ready(rdy[0]), .y(y4), .y_ch(ych4), .y_valid(yv4),
    .sel_err(se4), .busy(busy4), .done(done4)
`ifdef CH_MASK_EN
    , .ch_mask(mask4)
`endif
  );

  tdm_mux_scan #(.N_CH(5), .W(8)) u5 (
    .clk(clk), .reset(rst[1]), .d(d5), .mode(mode[1]), .sel_in(sel5),
    .start(start[1]), .out_ready(rdy[1]), .y(y5), .y_ch(ych5), .y_valid(yv5),
    .sel_err(se5), .busy(busy5), .done(done5)
`ifdef CH_MASK_EN
    , .ch_mask(mask5)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a burst is the set of channels still to emit; lowest pending goes next.
  logic [7:0] m_y[2];
  int         m_ych[2];
  bit         m_yv[2], m_se[2], m_done[2], m_burst[2];
  logic [4:0] m_todo[2];

  task automatic model_step(input int i);
    int         n, s, lo;
    logic [7:0] dv[5];
    logic [39:0] d4x;
    logic [4:0] en;
    d4x = {8'h00, d4};
    n = (i == 0) ? 4 : 5;
    for (int c = 0; c < 5; c++) dv[c] = (i == 0) ? d4x[c*8 +: 8] : d5[c*8 +: 8];
    s  = (i == 0) ? int'(sel4) : int'(sel5);
    en = 5'((1 << n) - 1);
`ifdef CH_MASK_EN
    en = en & ~((i == 0) ? {1'b0, mask4} : mask5);
`endif
    if (rst[i]) begin
      m_y[i] = '0; m_ych[i] = 0; m_yv[i] = 0; m_se[i] = 0;
      m_done[i] = 0; m_burst[i] = 0; m_todo[i] = '0;
      return;
    end
    m_done[i] = 0;
    if (!m_yv[i] || rdy[i]) begin
      if (!m_burst[i]) begin
        if (!mode[i]) begin
          m_yv[i]  = 1;
          m_ych[i] = s;
          m_se[i]  = (s >= n);
          m_y[i]   = (s < n) ? dv[s] : 8'h00;
        end else begin
          m_yv[i] = 0;
          if (start[i]) begin
            m_todo[i] = en;
            if (en == 0) m_done[i] = 1;
            else m_burst[i] = 1;
          end
        end
      end else if (m_todo[i] != 0) begin
        lo = 0;
        for (int c = 4; c >= 0; c--) if (m_todo[i][c]) lo = c;
        m_y[i] = dv[lo]; m_ych[i] = lo; m_yv[i] = 1;
        m_todo[i][lo] = 1'b0;
      end else begin
        m_done[i] = 1; m_yv[i] = 0; m_burst[i] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("u4.y", 32'(y4), 32'(m_y[0]));
      cmp("u4.y_ch", 32'(ych4), 32'(m_ych[0]));
      cmp("u4.y_valid", 32'(yv4), 32'(m_yv[0]));
      cmp("u4.sel_err", 32'(se4), 32'(m_se[0]));
      cmp("u4.busy", 32'(busy4), 32'(m_burst[0]));
      cmp("u4.done", 32'(done4), 32'(m_done[0]));
      cmp("u5.y", 32'(y5), 32'(m_y[1]));
      cmp("u5.y_ch", 32'(ych5), 32'(m_ych[1]));
      cmp("u5.y_valid", 32'(yv5), 32'(m_yv[1]));
      cmp("u5.sel_err", 32'(se5), 32'(m_se[1]));
      cmp("u5.busy", 32'(busy5), 32'(m_burst[1]));
      cmp("u5.done", 32'(done5), 32'(m_done[1]));
    end
  end

  function automatic logic vld(input int i);
    return (i == 0) ? yv4 : yv5;
  endfunction
  function automatic int chn(input int i);
    return (i == 0) ? int'(ych4) : int'(ych5);
  endfunction
  function automatic logic dn(input int i);
    return (i == 0) ? done4 : done5;
  endfunction

  int acc[8];
  int nacc;
  int ndone;

  // Pulses start, then records accepted channels and done pulses under a ready pattern.
  task automatic run_scan(input int i, input int cycles, input logic [3:0] pat, input bit chg);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    nacc = 0;
    ndone = 0;
    for (int k = 0; k < cycles; k++) begin
      rdy[i] = pat[k % 4];
      if (vld(i) && rdy[i]) begin
        if (nacc < 8) acc[nacc] = chn(i);
        nacc++;
      end
      if (dn(i)) ndone++;
      @(negedge clk);
      if (chg && k == 3) d4 = 32'h8877_6655;
    end
    rdy[i] = 1'b1;
  endtask

  initial begin
    rst = 2'b11; mode = 2'b00; start = 2'b00; rdy = 2'b11;
    d4 = '0; d5 = '0; sel4 = '0; sel5 = '0;
`ifdef CH_MASK_EN
    mask4 = '0; mask5 = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    cmp("reset.y_valid", 32'(yv4), 32'd0);
    cmp("reset.busy", 32'(busy4), 32'd0);
    rst = 2'b00;

    // Manual select on both instances, including an out-of-range index.
    d4 = 32'h0100_0000; sel4 = 2'd3;
    d5 = 40'h55_44_33_22_11; sel5 = 3'd6;
    @(negedge clk);
    cmp("man.y_sel3", 32'(y4), 32'd1);
    cmp("man.ych_sel3", 32'(ych4), 32'd3);
    cmp("man.valid", 32'(yv4), 32'd1);
    cmp("man5.y_sel6", 32'(y5), 32'd0);
    cmp("man5.err_sel6", 32'(se5), 32'd1);
    sel4 = 2'd0; sel5 = 3'd2;
    @(negedge clk);
    cmp("man.y_sel0", 32'(y4), 32'd0);
    cmp("man5.y_sel2", 32'(y5), 32'h33);
    cmp("man5.err_clr", 32'(se5), 32'd0);

    // Free-running scan: beats A..D back to back, done after the last acceptance.
    d4 = 32'h0D0C_0B0A; mode[0] = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    cmp("scan.busy", 32'(busy4), 32'd1);
    cmp("scan.idle_valid", 32'(yv4), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cmp($sformatf("scan.y%0d", k), 32'(y4), 32'h0A + 32'(k));
      cmp($sformatf("scan.ych%0d", k), 32'(ych4), 32'(k));
    end
    @(negedge clk);
    cmp("scan.done", 32'(done4), 32'd1);
    cmp("scan.valid_off", 32'(yv4), 32'd0);
    @(negedge clk);
    cmp("scan.done_pulse", 32'(done4), 32'd0);

    // Stalled scan with data changing mid-burst.
    d4 = 32'h4433_2211;
    run_scan(0, 16, 4'b1001, 1'b1);
    cmp("stall.beats", 32'(nacc), 32'd4);
    for (int j = 0; j < 4; j++) cmp($sformatf("stall.ch%0d", j), 32'(acc[j]), 32'(j));
    cmp("stall.dones", 32'(ndone), 32'd1);

    // Five-channel scan never emits an index beyond 4.
    mode[1] = 1'b1;
    run_scan(1, 10, 4'b1111, 1'b0);
    cmp("scan5.beats", 32'(nacc), 32'd5);
    cmp("scan5.last_ch", 32'(acc[4]), 32'd4);
    cmp("scan5.dones", 32'(ndone), 32'd1);

    // Reset on the second beat aborts without done.
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cmp("abort.beat2_ch", 32'(ych5), 32'd1);
    rst[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b0;
    cmp("abort.valid", 32'(yv5), 32'd0);
    cmp("abort.busy", 32'(busy5), 32'd0);
    cmp("abort.done", 32'(done5), 32'd0);
    repeat (4) @(negedge clk);

`ifdef CH_MASK_EN
    mask4 = 4'b0101;
    run_scan(0, 8, 4'b1111, 1'b0);
    cmp("mask.beats", 32'(nacc), 32'd2);
    cmp("mask.ch_a", 32'(acc[0]), 32'd1);
    cmp("mask.ch_b", 32'(acc[1]), 32'd3);
    cmp("mask.dones", 32'(ndone), 32'd1);
    mask4 = 4'b1111;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    mask4 = 4'b0000;
    cmp("allmask.done", 32'(done4), 32'd1);
    cmp("allmask.valid", 32'(yv4), 32'd0);
    cmp("allmask.busy", 32'(busy4), 32'd0);
    repeat (3) @(negedge clk);
`endif

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
